rtc_reg_sequencer: RTL
======================

RTC_REG_SEQUENCER -- requirements
Module: rtc_reg_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of cycles to wait for bus_ack before aborting a transfer.
REQ-002 SHALL have parameter N_SLOTS, default 10, meaning the number of register slots; it is fixed at 10.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 start  in  1  one-cycle pulse that begins a sequence; sampled only in IDLE.
REQ-006 rd_nwr  in  1  1 = read the RTC into the registers, 0 = write the registers to the RTC; sampled with start.
REQ-007 slot_mask  in  10  one bit per slot: bit0 seg_hora, bit1 min_hora, bit2 hora_hora, bit3 dia_fecha, bit4 mes_fecha, bit5 jahr_fecha, bit6 seg_timer, bit7 min_timer, bit8 hora_timer, bit9 banderas_config; sampled with start.
REQ-008 reg_data_in  in  80  current register contents; slot i occupies bits [8i+7:8i].
REQ-009 bus_ack  in  1  RTC bus driver completion pulse.
REQ-010 bus_rd_data  in  8  read data from the driver; valid in the bus_ack cycle.
REQ-011 bus_req  out  1  transfer request to the RTC bus driver.
REQ-012 bus_wr  out  1  1 = write transfer, 0 = read transfer.
REQ-013 bus_addr  out  8  RTC address of the current slot.
REQ-014 bus_wr_data  out  8  write data for the current slot.
REQ-015 hold_n  out  10  active-low per-slot load enable.
REQ-016 data_out  out  8  value to load into the slot released by hold_n.
REQ-017 busy  out  1  high whenever the controller is not in IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 timeout_err  out  1  sticky error flag; cleared by the next accepted start.

Function
REQ-020 SHALL use states IDLE, SCAN, REQ, WAIT_ACK, LOAD, FIN.
REQ-021 In IDLE, start=1 SHALL latch rd_nwr and slot_mask, set idx=0, clear timeout_err, and go to SCAN; start outside IDLE SHALL be ignored.
REQ-022 SCAN SHALL spend one cycle per slot: if mask[idx]=1, go to REQ; else if idx=9, go to FIN; else idx++.
REQ-023 REQ SHALL last one cycle with bus_req=1, bus_addr=ADDR_TABLE[idx], bus_wr=~rd_nwr, bus_wr_data=reg_data_in slot idx, then go to WAIT_ACK.
REQ-024 bus_req, bus_addr, bus_wr and bus_wr_data SHALL be held stable through WAIT_ACK; bus_req SHALL fall in the cycle after bus_ack.
REQ-025 In WAIT_ACK, on bus_ack: a read SHALL capture bus_rd_data and go to LOAD; a write SHALL advance idx (or go to FIN if idx=9) and return to SCAN.
REQ-026 LOAD SHALL last exactly one cycle with hold_n[idx]=0 and data_out equal to the captured byte, then advance as in REQ-025.
REQ-027 Outside LOAD, hold_n SHALL be all ones; at most one hold_n bit is low in any cycle.
REQ-028 The wait counter SHALL reset on entry to WAIT_ACK; if TIMEOUT_CYC cycles elapse without bus_ack, the controller SHALL set timeout_err, drop bus_req, and go to FIN, skipping the remaining slots.
REQ-029 FIN SHALL pulse done for one cycle, then return to IDLE.
REQ-030 A mask of all zeros SHALL produce done exactly 11 cycles after start, with no bus_req.
REQ-031 bus_ack outside WAIT_ACK SHALL be ignored.

Reset
REQ-032 reset_n=0 SHALL asynchronously force IDLE, idx=0, bus_req=0, bus_wr=0, bus_addr=0x00, bus_wr_data=0x00, hold_n=10'h3FF, data_out=0x00, busy=0, done=0, timeout_err=0.
REQ-033 Reset in mid-sequence SHALL abandon the transfer with no done pulse and no hold_n pulse.

Structure
REQ-034 The shared package SHALL hold the state encoding, the slot indices, and ADDR_TABLE: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43, 0x00.
REQ-035 The timeout counter SHALL be a separate sub-module, rtc_timeout_counter (clear, enable, expired).

Verification
REQ-036 Write, mask=10'h001, reg_data_in slot0=0x59, bus_ack 3 cycles after bus_req -> bus_addr=0x21, bus_wr=1, bus_wr_data=0x59, done pulses, hold_n stays 3FF.
REQ-037 Read, mask=10'h201, bus_rd_data 0x12 then 0x80 -> hold_n[0] low with data_out=0x12, later hold_n[9] low with data_out=0x80 at addr 0x00, then one done.
REQ-038 Read, mask=10'h3FF, ack always 1 cycle -> 10 transfers in the order of REQ-034, each slot loaded once, busy high throughout.
REQ-039 Mask=10'h004, no bus_ack -> timeout_err=1 after 255 wait cycles, bus_req=0, done pulses, next start clears timeout_err.
REQ-040 Reset_n pulsed low during WAIT_ACK of slot 4 -> all outputs at reset values immediately, no done; new start then runs normally.
REQ-041 Start pulsed while busy, and spurious bus_ack in IDLE -> no effect on sequence or outputs.

Source files
------------

// File: rtl/rtc_reg_sequencer_pkg.sv
// Shared definitions for the RTC register sequencer: controller states,
// slot numbering and the RTC address of every slot.
package rtc_reg_sequencer_pkg;

  localparam int SLOT_COUNT = 10;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WAIT_ACK,
    LOAD,
    FIN
  } seq_state_e;

  typedef enum logic [3:0] {
    SLOT_SEG_HORA        = 4'd0,
    SLOT_MIN_HORA        = 4'd1,
    SLOT_HORA_HORA       = 4'd2,
    SLOT_DIA_FECHA       = 4'd3,
    SLOT_MES_FECHA       = 4'd4,
    SLOT_JAHR_FECHA      = 4'd5,
    SLOT_SEG_TIMER       = 4'd6,
    SLOT_MIN_TIMER       = 4'd7,
    SLOT_HORA_TIMER      = 4'd8,
    SLOT_BANDERAS_CONFIG = 4'd9
  } slot_e;

  // Element 0 is the rightmost entry, so the list reads slot 9 down to slot 0.
  localparam logic [SLOT_COUNT-1:0][7:0] ADDR_TABLE = {
    8'h00, 8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
  };

endpackage

// File: rtl/rtc_reg_sequencer_if.sv
// Handshake between the register sequencer and the RTC bus driver.
interface rtc_reg_sequencer_if;

  logic       bus_req;
  logic       bus_wr;
  logic [7:0] bus_addr;
  logic [7:0] bus_wr_data;
  logic       bus_ack;
  logic [7:0] bus_rd_data;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wr_data,
    input  bus_ack, bus_rd_data
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wr_data,
    output bus_ack, bus_rd_data
  );

endinterface

// File: rtl/rtc_timeout_counter.sv
// Wait-cycle counter: expired rises on the LIMIT-th enabled cycle after clear.
module rtc_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/rtc_reg_sequencer.sv
// RTC register sequencer: walks the ten clock/calendar/timer slots and moves
// each selected byte between the register file and the RTC bus driver.
module rtc_reg_sequencer
  import rtc_reg_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int N_SLOTS     = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   rd_nwr,
  input  logic [N_SLOTS-1:0]     slot_mask,
  input  logic [8*N_SLOTS-1:0]   reg_data_in,
  rtc_reg_sequencer_if.master    bus,
  output logic [N_SLOTS-1:0]     hold_n,
  output logic [7:0]             data_out,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err
);

  seq_state_e         state;
  logic [3:0]         idx;
  logic [N_SLOTS-1:0] mask_q;
  logic               rd_q;
  logic               wait_expired;
  logic               last_slot;

  assign last_slot = (idx == SLOT_BANDERAS_CONFIG);
  assign busy      = (state != IDLE);

  rtc_timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_wait_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == REQ),
    .enable  (state == WAIT_ACK),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      idx             <= '0;
      mask_q          <= '0;
      rd_q            <= 1'b0;
      bus.bus_req     <= 1'b0;
      bus.bus_wr      <= 1'b0;
      bus.bus_addr    <= 8'h00;
      bus.bus_wr_data <= 8'h00;
      hold_n          <= '1;
      data_out        <= 8'h00;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rd_q        <= rd_nwr;
            mask_q      <= slot_mask;
            idx         <= '0;
            timeout_err <= 1'b0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (mask_q[idx]) begin
            bus.bus_req     <= 1'b1;
            bus.bus_wr      <= ~rd_q;
            bus.bus_addr    <= ADDR_TABLE[idx];
            bus.bus_wr_data <= reg_data_in[{idx, 3'b000} +: 8];
            state           <= REQ;
          end else if (last_slot) begin
            state <= FIN;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        REQ: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack arriving on the final allowed wait cycle still wins over the timeout.
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (rd_q) begin
              data_out <= bus.bus_rd_data;
              hold_n   <= ~({{(N_SLOTS-1){1'b0}}, 1'b1} << idx);
              state    <= LOAD;
            end else if (last_slot) begin
              state <= FIN;
            end else begin
              idx   <= idx + 4'd1;
              state <= SCAN;
            end
          end else if (wait_expired) begin
            bus.bus_req <= 1'b0;
            timeout_err <= 1'b1;
            state       <= FIN;
          end
        end
        LOAD: begin
          hold_n <= '1;
          if (last_slot) begin
            state <= FIN;
          end else begin
            idx   <= idx + 4'd1;
            state <= SCAN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
